// File: rtl/sonic_rx_arb_pkg.sv
// sonic_rx_arb_pkg
// Shared definitions for the two-requester RX stream lane arbiter:
//   arb_state_e      - arbiter FSM state encoding (IDLE / GRANT0 / GRANT1)
//   DATA_W_DEFAULT   - default payload width (64 data + 8 control bits)
//   MAX_HOLD_DEFAULT - default beats per grant before hold_err is raised
package sonic_rx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  localparam int DATA_W_DEFAULT   = 72;
  localparam int MAX_HOLD_DEFAULT = 256;

endpackage

// File: rtl/sonic_rx_arb_rr2.sv
// sonic_rx_arb_rr2
// Two-way round-robin pick. When both requests are present the requester
// that did not win last time is chosen.
// Ports:
//   req0, req1  in  : request lines
//   last_grant  in  : index of the most recent winner
//   gnt_valid   out : at least one request present
//   gnt_idx     out : chosen requester index (meaningful when gnt_valid)
module sonic_rx_arb_rr2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_idx
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = 1'b0;
    if (req0 && req1) begin
      gnt_idx = ~last_grant;
    end else if (req1) begin
      gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/sonic_rx_st_lane_arbiter.sv
// sonic_rx_st_lane_arbiter
// Packet-granular 2:1 arbiter merging two RX streams onto one output stream
// feeding the lane decoder timing adapter. A grant is taken only on an sop
// beat and held until the eop beat; non-sop beats that arrive while idle are
// accepted and dropped. The output stage is a single register slice.
//
// Optional feature macro: SONIC_RX_ARB_STATS_EN adds the pkt_cnt0, pkt_cnt1
// and drop_cnt statistics outputs.
//
// Ports:
//   clk, reset_n                    : clock, async active-low reset
//   inN_valid/data/sop/eop, inN_ready : requester streams (N = 0, 1)
//   out_valid/data/sop/eop/src, out_ready : merged output stream
//   hold_err                        : sticky; grant ran to MAX_HOLD beats or
//                                     an sop was seen inside a packet
//   pkt_cnt0, pkt_cnt1, drop_cnt    : statistics (macro builds only)
//
// state  | meaning
// IDLE   | no grant; waiting for an sop, non-sop beats are dropped
// GRANT0 | requester 0 owns the output until its eop beat is accepted
// GRANT1 | requester 1 owns the output until its eop beat is accepted
module sonic_rx_st_lane_arbiter
  import sonic_rx_arb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_sop,
  input  logic              in0_eop,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_sop,
  input  logic              in1_eop,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_src,
  input  logic              out_ready,
  output logic              hold_err
`ifdef SONIC_RX_ARB_STATS_EN
  ,
  output logic [31:0]       pkt_cnt0,
  output logic [31:0]       pkt_cnt1,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  arb_state_e        state, state_nxt;
  logic              last_grant;
  logic [CNT_W-1:0]  beat_cnt;
  logic              pick_valid;
  logic              pick_idx;
  logic              out_load;
  logic              fwd0, fwd1, fwd;
  logic              fwd_idx;
  logic [DATA_W-1:0] fwd_data;
  logic              fwd_sop, fwd_eop;

  sonic_rx_arb_rr2 u_rr2 (
    .req0       (in0_valid & in0_sop),
    .req1       (in1_valid & in1_sop),
    .last_grant (last_grant),
    .gnt_valid  (pick_valid),
    .gnt_idx    (pick_idx)
  );

  // The output slice can take a new beat when it is empty or being drained.
  assign out_load = out_ready | ~out_valid;

  always_comb begin
    state_nxt = state;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    case (state)
      IDLE: begin
        // sop beats wait for the grant; anything else is swallowed here.
        in0_ready = in0_valid & ~in0_sop;
        in1_ready = in1_valid & ~in1_sop;
        if (pick_valid) begin
          state_nxt = pick_idx ? GRANT1 : GRANT0;
        end
      end
      GRANT0: begin
        in0_ready = out_load;
        if (in0_valid && out_load && in0_eop) begin
          state_nxt = IDLE;
        end
      end
      GRANT1: begin
        in1_ready = out_load;
        if (in1_valid && out_load && in1_eop) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // State already sits in IDLE during reset; this keeps readies low too.
    in0_ready = in0_ready & reset_n;
    in1_ready = in1_ready & reset_n;
  end

  assign fwd0     = (state == GRANT0) & in0_valid & in0_ready;
  assign fwd1     = (state == GRANT1) & in1_valid & in1_ready;
  assign fwd      = fwd0 | fwd1;
  assign fwd_idx  = (state == GRANT1);
  assign fwd_data = fwd_idx ? in1_data : in0_data;
  assign fwd_sop  = fwd_idx ? in1_sop  : in0_sop;
  assign fwd_eop  = fwd_idx ? in1_eop  : in0_eop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      hold_err   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_src    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fwd && fwd_eop) begin
        last_grant <= fwd_idx;
      end
      if (fwd) begin
        if (fwd_eop) begin
          beat_cnt <= '0;
        end else if (beat_cnt < CNT_W'(MAX_HOLD)) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        // This beat is number MAX_HOLD or later, or a stray sop mid-packet.
        if ((beat_cnt >= CNT_W'(MAX_HOLD - 1)) || (fwd_sop && (beat_cnt != '0))) begin
          hold_err <= 1'b1;
        end
      end
      if (out_load) begin
        out_valid <= fwd;
        if (fwd) begin
          out_data <= fwd_data;
          out_sop  <= fwd_sop;
          out_eop  <= fwd_eop;
          out_src  <= fwd_idx;
        end
      end
    end
  end

`ifdef SONIC_RX_ARB_STATS_EN
  logic        drop0, drop1;
  logic [16:0] drop_sum;

  assign drop0    = (state == IDLE) & in0_valid & in0_ready;
  assign drop1    = (state == IDLE) & in1_valid & in1_ready;
  assign drop_sum = {1'b0, drop_cnt} + 17'(drop0) + 17'(drop1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
      drop_cnt <= '0;
    end else begin
      if (fwd0 && in0_eop) begin
        pkt_cnt0 <= pkt_cnt0 + 32'd1;
      end
      if (fwd1 && in1_eop) begin
        pkt_cnt1 <= pkt_cnt1 + 32'd1;
      end
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_sonic_rx_st_lane_arbiter.sv
module tb_sonic_rx_st_lane_arbiter;

  localparam int DW = 72;
  localparam int MH = 256;

  typedef struct {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          v[2];
  logic          s[2];
  logic          e[2];
  logic [DW-1:0] d[2];
  logic          out_ready;
  logic          in0_ready, in1_ready;
  logic          out_valid, out_sop, out_eop, out_src, hold_err;
  logic [DW-1:0] out_data;
`ifdef SONIC_RX_ARB_STATS_EN
  logic [31:0]   pkt_cnt0, pkt_cnt1;
  logic [15:0]   drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  sonic_rx_st_lane_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in0_valid (v[0]),
    .in0_data  (d[0]),
    .in0_sop   (s[0]),
    .in0_eop   (e[0]),
    .in0_ready (in0_ready),
    .in1_valid (v[1]),
    .in1_data  (d[1]),
    .in1_sop   (s[1]),
    .in1_eop   (e[1]),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_src   (out_src),
    .out_ready (out_ready),
    .hold_err  (hold_err)
`ifdef SONIC_RX_ARB_STATS_EN
    ,
    .pkt_cnt0  (pkt_cnt0),
    .pkt_cnt1  (pkt_cnt1),
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Requester sources
  beat_t q0[$];
  beat_t q1[$];
  int    pct = 100;

  // Behavioural model: who owns the output, the packet in progress and
  // the contents of the one-deep output slice.
  int            m_owner;   // -1 when nobody holds a grant
  int            m_last;
  int            m_beats;
  bit            m_herr;
  bit            m_ov;
  logic [DW-1:0] m_od;
  bit            m_os, m_oe, m_osrc;
  int            m_drop;
  int unsigned   m_pkt[2];
  bit            m_acc[2];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_rdy(input int n);
    if (!reset_n) return 1'b0;
    if (m_owner < 0) return v[n] & ~s[n];
    if (m_owner == n) return out_ready | ~m_ov;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_last = 1; m_beats = 0; m_herr = 0;
    m_ov = 0; m_od = '0; m_os = 0; m_oe = 0; m_osrc = 0;
    m_drop = 0; m_pkt[0] = 0; m_pkt[1] = 0;
    m_acc[0] = 0; m_acc[1] = 0;
  endfunction

  function automatic void model_step();
    bit a[2];
    int k;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int n = 0; n < 2; n++) a[n] = v[n] & exp_rdy(n);
    m_acc[0] = a[0];
    m_acc[1] = a[1];
    if (m_owner < 0) begin
      m_drop = m_drop + int'(a[0]) + int'(a[1]);
      if (m_drop > 65535) m_drop = 65535;
      if (out_ready) m_ov = 0;
      if (v[0] && s[0] && v[1] && s[1]) m_owner = (m_last == 1) ? 0 : 1;
      else if (v[0] && s[0]) m_owner = 0;
      else if (v[1] && s[1]) m_owner = 1;
    end else begin
      k = m_owner;
      if (out_ready || !m_ov) m_ov = a[k];
      if (a[k]) begin
        m_od = d[k]; m_os = s[k]; m_oe = e[k]; m_osrc = k[0];
        if (s[k] && m_beats > 0) m_herr = 1;
        m_beats++;
        if (m_beats >= MH) m_herr = 1;
        if (e[k]) begin
          m_owner = -1;
          m_last  = k;
          m_beats = 0;
          m_pkt[k]++;
        end
      end
    end
  endfunction

  task automatic drive();
    beat_t b;
    for (int n = 0; n < 2; n++) begin
      if (m_acc[n]) begin
        if (n == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        v[n] = 0;
      end
      if (!v[n]) begin
        if (((n == 0) ? q0.size() : q1.size()) > 0 && $urandom_range(99) < pct) begin
          b = (n == 0) ? q0[0] : q1[0];
          v[n] = 1; d[n] = b.d; s[n] = b.s; e[n] = b.e;
        end else begin
          v[n] = 0; s[n] = 0; e[n] = 0;
        end
      end
    end
    m_acc[0] = 0;
    m_acc[1] = 0;
  endtask

  task automatic check_all();
    chk("in0_ready", in0_ready, exp_rdy(0));
    chk("in1_ready", in1_ready, exp_rdy(1));
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_data", out_data, m_od);
      chk("out_sop", out_sop, m_os);
      chk("out_eop", out_eop, m_oe);
      chk("out_src", out_src, m_osrc);
    end
    chk("hold_err", hold_err, m_herr);
`ifdef SONIC_RX_ARB_STATS_EN
    chk("pkt_cnt0", pkt_cnt0, m_pkt[0]);
    chk("pkt_cnt1", pkt_cnt1, m_pkt[1]);
    chk("drop_cnt", drop_cnt, m_drop);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    drive();
    @(negedge clk);
    check_all();
  endtask

  task automatic push_pkt(input int n, input int len, input int base, input bit mid_sop);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = DW'(base + i);
      b.s = (i == 0) || (mid_sop && i == 1);
      b.e = (i == len - 1);
      if (n == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic clear_src();
    q0.delete(); q1.delete();
    for (int n = 0; n < 2; n++) begin
      v[n] = 0; s[n] = 0; e[n] = 0; d[n] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    clear_src();
    model_reset();
    v[0] = 1; d[0] = DW'(8'h5A);   // stray non-sop beat must not be accepted in reset
    @(negedge clk);
    chk("rst_in0_ready", in0_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_src", out_src, 1'b0);
    chk("rst_hold_err", hold_err, 1'b0);
    v[0] = 0;
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    bit exp_v[12];
    int exp_d[12];
    int seen, nxt;
    bit found;
    beat_t b;

    out_ready = 1;
    clear_src();
    model_reset();

    // Simultaneous sop after reset: req0 first, one gap cycle, then req1
    do_reset();
    push_pkt(0, 4, 'h100, 0);
    push_pkt(1, 4, 'h200, 0);
    exp_v = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    exp_d = '{0, 0, 'h100, 'h101, 'h102, 'h103, 0, 'h200, 'h201, 'h202, 'h203, 0};
    for (int i = 0; i < 12; i++) begin
      step();
      chk("rr_valid", out_valid, exp_v[i]);
      if (exp_v[i]) begin
        chk("rr_src", out_src, (i < 6) ? 1'b0 : 1'b1);
        chk("rr_data", out_data, DW'(exp_d[i]));
      end
    end

    // Mid-packet stall of 5 cycles
    do_reset();
    push_pkt(0, 6, 'h300, 0);
    for (int i = 0; i < 4; i++) step();
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data", out_data, DW'('h301));
      chk("stall_in0_ready", in0_ready, 1'b0);
    end
    out_ready = 1;
    nxt = 'h302;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) begin
        chk("stall_seq", out_data, DW'(nxt));
        nxt++;
      end
    end
    chk("stall_count", DW'(nxt), DW'('h306));

    // Non-sop beat while idle is dropped
    do_reset();
    b.d = DW'('h33); b.s = 0; b.e = 0;
    q1.push_back(b);
    step();
    chk("drop_in1_ready", in1_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drop_no_out", out_valid, 1'b0);
    end
    chk("drop_q_empty", DW'(q1.size()), '0);
`ifdef SONIC_RX_ARB_STATS_EN
    chk("drop_cnt_lit", drop_cnt, DW'(1));
`endif

    // Reset during beat 2 of a 6-beat packet
    do_reset();
    push_pkt(0, 6, 'h400, 0);
    for (int i = 0; i < 4; i++) step();
    reset_n = 0;
    clear_src();
    model_reset();
    step();
    step();
    chk("rstmid_valid", out_valid, 1'b0);
    @(negedge clk);
    reset_n = 1;
    push_pkt(1, 2, 'h500, 0);
    push_pkt(0, 2, 'h600, 0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (out_valid) begin
        found = 1;
        chk("rstmid_first_src", out_src, 1'b0);
        chk("rstmid_first_data", out_data, DW'('h600));
      end
    end
    chk("rstmid_found", found, 1'b1);
    for (int i = 0; i < 10; i++) step();

    // Long packet past MAX_HOLD
    do_reset();
    push_pkt(0, 300, 'h1000, 0);
    seen = 0;
    for (int i = 0; i < 400 && seen < 300; i++) begin
      step();
      if (out_valid) begin
        seen++;
        chk("long_herr", hold_err, (seen >= MH) ? 1'b1 : 1'b0);
        chk("long_data", out_data, DW'('h1000 + seen - 1));
      end
    end
    chk("long_count", DW'(seen), DW'(300));
    step();
    chk("long_herr_sticky", hold_err, 1'b1);

`ifdef SONIC_RX_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) push_pkt(0, 3, 'h700 + 16 * i, 0);
    for (int i = 0; i < 2; i++) push_pkt(1, 2, 'h800 + 16 * i, 0);
    for (int i = 0; i < 60; i++) step();
    chk("stats_pkt0", pkt_cnt0, DW'(3));
    chk("stats_pkt1", pkt_cnt1, DW'(2));
`endif

    // Randomized traffic with backpressure, gaps, strays and mid-packet sops
    do_reset();
    pct = 70;
    for (int c = 0; c < 4000; c++) begin
      out_ready = ($urandom_range(3) != 0);
      for (int n = 0; n < 2; n++) begin
        if (((n == 0) ? q0.size() : q1.size()) < 3 && $urandom_range(7) == 0) begin
          case ($urandom_range(19))
            0, 1: begin
              b.d = DW'($urandom); b.s = 0; b.e = $urandom_range(1);
              if (n == 0) q0.push_back(b); else q1.push_back(b);
            end
            2: push_pkt(n, 2 + $urandom_range(4), $urandom, 1);
            default: push_pkt(n, 1 + $urandom_range(7), $urandom, 0);
          endcase
        end
      end
      step();
    end
    out_ready = 1;
    pct = 100;
    for (int i = 0; i < 200; i++) step();
    chk("rand_drained", DW'(q0.size() + q1.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
